multi_sel_arb: RTL and testbench



---
 rtl/multi_sel_arb.sv | 138 +++++++++++++
 tb/tb_multi_sel_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multi_sel_arb.sv
// Shared shift-add multiplier: one arbitrated operand per job, emitting d*1, d*3, d*7, d*8 on 4 cycles; next job may issue in the x8 cycle.
// Results have no backpressure, requesters wait on req_ready; round-robin when MULTI_SEL_ARB_RR_EN is defined, else fixed priority.
module multi_sel_arb #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 res_valid,
   output logic [IDW-1:0]       res_id,
   output logic [1:0]           res_phase,
   output logic [DW+2:0]        res_data,
   output logic                 busy
);
   localparam int OW = DW + 3;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t         state, state_nxt;
   logic [1:0]     cnt;
   logic [DW-1:0]  d_reg;
   logic           accept, hs;
   logic           lo_any;
   logic [IDW-1:0] lo_id, win_id;
   logic [DW-1:0]  win_data;
   logic [OW-1:0]  dx, x3, x7, x8;

   always_comb begin
      lo_any = 1'b0;
      lo_id  = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_any = 1'b1;
            lo_id  = IDW'(i);
         end
      end
   end

`ifdef MULTI_SEL_ARB_RR_EN
   logic           hi_any;
   logic [IDW-1:0] hi_id, last;

   // Prefer the lowest valid index above the last winner, else wrap to the lowest overall.
   always_comb begin
      hi_any = 1'b0;
      hi_id  = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i] && (IDW'(i) > last)) begin
            hi_any = 1'b1;
            hi_id  = IDW'(i);
         end
      end
   end

   assign win_id = hi_any ? hi_id : lo_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= IDW'(NREQ-1);
      end else if (hs) begin
         last <= win_id;
      end
   end
`else
   assign win_id = lo_id;
`endif

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_id == IDW'(i)) win_data = req_data[i*DW +: DW];
      end
   end

   assign dx = {3'b000, d_reg};
   assign x3 = (dx << 1) + dx;
   assign x7 = (dx << 3) - dx;
   assign x8 = dx << 3;
   assign hs = |req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = RUN;
         RUN:     if ((cnt == 2'd3) && !hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept    = (state == IDLE) || (cnt == 2'd3);
      busy      = res_valid;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = !rst && accept && lo_any && (win_id == IDW'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= 2'd0;
         d_reg     <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_phase <= 2'd0;
         res_data  <= '0;
      end else if (hs) begin
         cnt       <= 2'd0;
         d_reg     <= win_data;
         res_valid <= 1'b1;
         res_id    <= win_id;
         res_phase <= 2'd0;
         res_data  <= {3'b000, win_data};
      end else if (state == RUN) begin
         if (cnt != 2'd3) begin
            cnt       <= cnt + 2'd1;
            res_phase <= cnt + 2'd1;
            case (cnt)
               2'd0:    res_data <= x3;
               2'd1:    res_data <= x7;
               default: res_data <= x8;
            endcase
         end else begin
            res_valid <= 1'b0;
            res_data  <= '0;
         end
      end
   end
endmodule

// File: tb/tb_multi_sel_arb.sv
// Randomised scoreboard bench for multi_sel_arb: a reference model predicts grants and the x1/x3/x7/x8
// result stream, and a negedge monitor compares every cycle, including idle and reset cycles.
`timescale 1ns/1ps
module tb_multi_sel_arb;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int IDW  = 2;
   localparam int OW   = DW + 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ*DW-1:0]  req_data = '0;
   logic [NREQ-1:0]     req_ready;
   logic                res_valid;
   logic [IDW-1:0]      res_id;
   logic [1:0]          res_phase;
   logic [OW-1:0]       res_data;
   logic                busy;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   typedef struct {
      int unsigned cyc;
      int          id;
      int          ph;
      int          data;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          m_last = NREQ - 1;
   int unsigned m_free = 0;
   int          mult[4] = '{1, 3, 7, 8};

   multi_sel_arb #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_phase (res_phase),
      .res_data  (res_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [NREQ*DW-1:0] rnd_data();
      logic [NREQ*DW-1:0] r;
      for (int i = 0; i < NREQ; i++) r[i*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   // One clock cycle: drive inputs, then predict and check the grant for this cycle.
   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d, input logic r);
      int              w;
      int              c;
      int              dv;
      logic [NREQ-1:0] exp_rdy;
      @(posedge clk);
      #1;
      req_valid = v;
      req_data  = d;
      rst       = r;
      @(negedge clk);
      if (r) begin
         checks++;
         if (res_valid !== 1'b0 || res_data !== '0 || busy !== 1'b0 || req_ready !== '0 ||
             res_id !== '0 || res_phase !== 2'd0) begin
            failures++;
            $display("FAIL reset_clear: res_valid=%0b res_data=%0d busy=%0b req_ready=%b res_id=%0d res_phase=%0d, required all zero",
                     res_valid, res_data, busy, req_ready, res_id, res_phase);
         end
         sb.delete();
         m_last = NREQ - 1;
         m_free = 0;
      end else begin
         w = -1;
`ifdef MULTI_SEL_ARB_RR_EN
         for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (w < 0 && v[c]) w = c;
         end
`else
         for (c = 0; c < NREQ; c++) begin
            if (w < 0 && v[c]) w = c;
         end
`endif
         exp_rdy = '0;
         if (cyc >= m_free && w >= 0) exp_rdy[w] = 1'b1;
         checks++;
         if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL grant: cycle %0d req_valid=%b req_ready=%b, required %b", cyc, v, req_ready, exp_rdy);
         end
         if (exp_rdy != '0) begin
            dv = int'(d[w*DW +: DW]);
            for (int p = 0; p < 4; p++) sb.push_back('{cyc + 1 + p, w, p, dv * mult[p]});
            m_free = cyc + 4;
            m_last = w;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (res_valid !== 1'b1 || busy !== 1'b1 || res_id !== IDW'(e.id) ||
                res_phase !== 2'(e.ph) || res_data !== OW'(e.data)) begin
               failures++;
               $display("FAIL result: cycle %0d got v=%0b busy=%0b id=%0d ph=%0d data=%0d, required v=1 busy=1 id=%0d ph=%0d data=%0d",
                        cyc, res_valid, busy, res_id, res_phase, res_data, e.id, e.ph, e.data);
            end
         end else if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== '0) begin
            failures++;
            $display("FAIL idle: cycle %0d got v=%0b busy=%0b data=%0d, required v=0 busy=0 data=0",
                     cyc, res_valid, busy, res_data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NREQ*DW-1:0] d;
      logic [NREQ-1:0]    v;

      step('0, '0, 1'b1);
      step('0, '0, 1'b1);

      // Single requester 0 with operand 5, then requester 2 with the maximum operand.
      d = rnd_data(); d[0 +: DW] = 8'd5;
      step(4'b0001, d, 1'b0);
      for (int i = 0; i < 6; i++) step('0, rnd_data(), 1'b0);
      d = rnd_data(); d[2*DW +: DW] = 8'hFF;
      step(4'b0100, d, 1'b0);
      for (int i = 0; i < 6; i++) step('0, rnd_data(), 1'b0);

      // All requesters continuously valid, then a reset in the middle of a job.
      for (int i = 0; i < 22; i++) step(4'b1111, rnd_data(), 1'b0);
      step(4'b1111, rnd_data(), 1'b1);
      for (int i = 0; i < 2; i++) step('0, rnd_data(), 1'b0);

      // Requester 1 arrives during phase 1 of a requester 0 job.
      step(4'b0001, rnd_data(), 1'b0);
      step(4'b0000, rnd_data(), 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0010, rnd_data(), 1'b0);
      for (int i = 0; i < 6; i++) step('0, rnd_data(), 1'b0);

      // Reset during phase 1 of a requester 3 job with requesters 1 and 3 waiting.
      step(4'b1000, rnd_data(), 1'b0);
      step(4'b1010, rnd_data(), 1'b0);
      step(4'b1010, rnd_data(), 1'b1);
      for (int i = 0; i < 12; i++) step(4'b1010, rnd_data(), 1'b0);
      for (int i = 0; i < 6; i++) step('0, rnd_data(), 1'b0);

      for (int n = 0; n < 400; n++) begin
         v = NREQ'($urandom) & NREQ'($urandom);
         if ($urandom_range(0, 3) == 0) v = '1;
         step(v, rnd_data(), $urandom_range(0, 99) == 0);
      end
      for (int i = 0; i < 6; i++) step('0, rnd_data(), 1'b0);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expected results never presented, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
